// File: rtl/ofdm_payload_generator_if.sv
// ofdm_payload_generator_if
//   Stream bundle between the QAM symbol source, the payload generator and
//   the downstream IFFT.
//   Signals:
//     in_data_en          symbol valid from the source
//     in_data_i/q         symbol I/Q (DATA_SIZE, two's complement)
//     o_flag_ready_recive generator ready for a symbol (combinational)
//     out_done            one-cycle strobe per emitted bin
//     out_data_i/q        emitted bin I/Q (registered)
//     o_counter_data      index of the bin on out_data_*, zero-extended to 16
//     i_wayt_recive_data  downstream ready
//   Modports: slave = generator side, master = source/sink side.
interface ofdm_payload_generator_if #(
  parameter int unsigned DATA_SIZE = 16
) ();
  logic                 in_data_en;
  logic [DATA_SIZE-1:0] in_data_i;
  logic [DATA_SIZE-1:0] in_data_q;
  logic                 o_flag_ready_recive;
  logic                 out_done;
  logic [DATA_SIZE-1:0] out_data_i;
  logic [DATA_SIZE-1:0] out_data_q;
  logic [15:0]          o_counter_data;
  logic                 i_wayt_recive_data;

  modport slave (
    input  in_data_en, in_data_i, in_data_q, i_wayt_recive_data,
    output o_flag_ready_recive, out_done, out_data_i, out_data_q, o_counter_data
  );

  modport master (
    output in_data_en, in_data_i, in_data_q, i_wayt_recive_data,
    input  o_flag_ready_recive, out_done, out_data_i, out_data_q, o_counter_data
  );
endinterface

// File: rtl/ofdm_payload_generator.sv
// ofdm_payload_generator
//   Places a stream of QAM symbols onto the subcarriers of one OFDM symbol and
//   emits the frequency-domain frame in IFFT bin order 0..N_FFT-1, one bin per
//   emit. Active bins carry input symbols, DC/guard bins carry zero. No frame
//   buffer: each data bin is emitted the cycle after its symbol is accepted.
//   Optional feature macro: OFDM_PAYLOAD_PILOT_EN -- active bins also set in
//   PILOT_MASK emit {PILOT_VALUE, 0} and consume no input.
//   Ports:
//     i_clk    clock, rising edge
//     i_reset  asynchronous active-high reset
//     bus      ofdm_payload_generator_if.slave (symbol in, bin out, handshakes)
module ofdm_payload_generator #(
  parameter int unsigned        DATA_SIZE       = 16,
  parameter int unsigned        N_FFT           = 256,
  // bins 1..100 and 156..255 active, bin 0 (DC) and 101..155 null
  parameter logic [N_FFT-1:0]   SUBCARRIER_MASK = {{100{1'b1}}, {55{1'b0}}, {100{1'b1}}, 1'b0}
`ifdef OFDM_PAYLOAD_PILOT_EN
  ,
  parameter logic [N_FFT-1:0]   PILOT_MASK      = (256'd1 << 25) | (256'd1 << 75) |
                                                  (256'd1 << 181) | (256'd1 << 231),
  parameter logic [DATA_SIZE-1:0] PILOT_VALUE   = 16'h2D41
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  ofdm_payload_generator_if.slave bus
);

  localparam int unsigned KW = (N_FFT > 1) ? $clog2(N_FFT) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  state_t               state_next;
  logic [KW-1:0]        k;
  logic                 active_bin;
  logic                 pilot_bin;
  logic                 data_bin;
  logic                 last_bin;
  logic                 ready;
  logic                 accept;
  logic                 emit;
  logic [DATA_SIZE-1:0] bin_i;
  logic [DATA_SIZE-1:0] bin_q;
  logic                 done_r;
  logic [DATA_SIZE-1:0] data_i_r;
  logic [DATA_SIZE-1:0] data_q_r;
  logic [15:0]          cnt_r;

  assign active_bin = SUBCARRIER_MASK[k];

`ifdef OFDM_PAYLOAD_PILOT_EN
  localparam logic [DATA_SIZE-1:0] PILOT_I = PILOT_VALUE;
  assign pilot_bin = active_bin & PILOT_MASK[k];
`else
  localparam logic [DATA_SIZE-1:0] PILOT_I = '0;
  assign pilot_bin = 1'b0;
`endif

  assign data_bin = active_bin & ~pilot_bin;
  assign last_bin = (k == KW'(N_FFT - 1));

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (emit) state_next = RUN;
      RUN:     if (emit && last_bin) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/handshake logic. IDLE only releases bin 0 when the source shows a
  // symbol, so a frame never starts without input; no symbol is taken there.
  always_comb begin
    ready  = 1'b0;
    accept = 1'b0;
    emit   = 1'b0;
    unique case (state)
      IDLE: emit = bus.in_data_en & bus.i_wayt_recive_data;
      RUN: begin
        ready  = data_bin & bus.i_wayt_recive_data;
        accept = bus.in_data_en & ready;
        emit   = data_bin ? accept : bus.i_wayt_recive_data;
      end
      default: ;
    endcase

    bin_i = '0;
    bin_q = '0;
    if (pilot_bin) begin
      bin_i = PILOT_I;
    end else if (accept) begin
      bin_i = bus.in_data_i;
      bin_q = bus.in_data_q;
    end
  end

  // Bin counter and registered output bin
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      k        <= '0;
      done_r   <= 1'b0;
      data_i_r <= '0;
      data_q_r <= '0;
      cnt_r    <= '0;
    end else begin
      done_r <= emit;
      if (emit) begin
        data_i_r <= bin_i;
        data_q_r <= bin_q;
        cnt_r    <= 16'(k);
        k        <= last_bin ? '0 : k + 1'b1;
      end
    end
  end

  assign bus.o_flag_ready_recive = ready;
  assign bus.out_done            = done_r;
  assign bus.out_data_i          = data_i_r;
  assign bus.out_data_q          = data_q_r;
  assign bus.o_counter_data      = cnt_r;

endmodule

// File: tb/tb_ofdm_payload_generator.sv
// tb_ofdm_payload_generator
//   Bench for ofdm_payload_generator. Symbol n is {n, -n}. Each frame's
//   expected bins are queued when the frame is started; a monitor pops one
//   entry per out_done strobe. Frames cover input gap, downstream stall,
//   guard-bin stretch, back-to-back frames and reset mid-frame.
module tb_ofdm_payload_generator;
  localparam int NB = 256;

  typedef struct {
    int unsigned k;
    logic [15:0] i;
    logic [15:0] q;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ofdm_payload_generator_if #(.DATA_SIZE(16)) bus ();

  ofdm_payload_generator #(
    .DATA_SIZE(16),
    .N_FFT    (256)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   kind[NB];      // 0 null, 1 data, 2 pilot
  int   sym_bin[NB+1]; // bin carrying the j-th data symbol of a frame
  int   dpf = 0;       // data symbols per frame
  int   nnull = 0;
  int   n = 1;         // symbol currently offered
  int   fsym = 0;      // symbols accepted in this frame
  int   nodata = 0;
  bit   pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic build_model();
    for (int k = 0; k < NB; k++) begin
      bit active;
      active = (k >= 1 && k <= 100) || (k >= 156 && k <= 255);
      kind[k] = active ? 1 : 0;
`ifdef OFDM_PAYLOAD_PILOT_EN
      if (active && (k == 25 || k == 75 || k == 181 || k == 231)) kind[k] = 2;
`endif
      if (kind[k] == 1) begin
        dpf++;
        sym_bin[dpf] = k;
      end
    end
    nnull = NB - dpf;
  endtask

  task automatic push_frame(input int base);
    int   j;
    exp_t x;
    j = 0;
    for (int k = 0; k < NB; k++) begin
      x.k = k;
      x.i = 16'h0000;
      x.q = 16'h0000;
      if (kind[k] == 2) x.i = 16'h2D41;
      else if (kind[k] == 1) begin
        x.i = 16'(base + j);
        x.q = 16'(0 - (base + j));
        j++;
      end
      exp_q.push_back(x);
    end
  endtask

  // One clock: drive at the falling edge, observe ready, advance on accept.
  task automatic cyc(input bit en, input bit wayt);
    logic [15:0] s;
    s = 16'(n);
    bus.in_data_en         = en;
    bus.i_wayt_recive_data = wayt;
    bus.in_data_i          = s;
    bus.in_data_q          = -s;
    #1;
    pending = en && bus.o_flag_ready_recive;
    if (en && wayt && !bus.o_flag_ready_recive) nodata++;
    if (!wayt) chk("stall_ready", 32'(bus.o_flag_ready_recive), 0);
    @(negedge clk);
    if (pending) begin
      n++;
      fsym++;
    end
  endtask

  task automatic run_frame(input int gap_at, input int stall_at, input int abort_at);
    int budget;
    bit gap_done;
    bit stall_done;
    push_frame(n);
    fsym = 0;
    nodata = 0;
    budget = 0;
    gap_done = 1'b0;
    stall_done = 1'b0;
    while (fsym < dpf && budget < 3000) begin
      budget++;
      if (fsym == abort_at) begin
        bus.in_data_en = 1'b0;
        bus.i_wayt_recive_data = 1'b0;
        @(posedge clk);
        #2;
        bus.in_data_en = 1'b1;
        bus.i_wayt_recive_data = 1'b1;
        #1;
        chk("pre_reset_ready", 32'(bus.o_flag_ready_recive), 1);
        rst = 1'b1;
        #1;
        chk("midrst_done",  32'(bus.out_done), 0);
        chk("midrst_i",     32'(bus.out_data_i), 0);
        chk("midrst_q",     32'(bus.out_data_q), 0);
        chk("midrst_cnt",   32'(bus.o_counter_data), 0);
        chk("midrst_ready", 32'(bus.o_flag_ready_recive), 0);
        @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        pending = 1'b0;
        return;
      end else if (fsym == gap_at && !gap_done) begin
        gap_done = 1'b1;
        repeat (5) begin
          cyc(1'b0, 1'b1);
          chk("gap_no_strobe", 32'(bus.out_done), 0);
        end
      end else if (fsym == stall_at && !stall_done) begin
        stall_done = 1'b1;
        repeat (10) begin
          cyc(1'b1, 1'b0);
          chk("stall_no_strobe", 32'(bus.out_done), 0);
          chk("stall_cnt",  32'(bus.o_counter_data), 32'(sym_bin[stall_at]));
          chk("stall_data", 32'(bus.out_data_i), 32'(16'(n - 1)));
        end
      end else begin
        cyc(1'b1, 1'b1);
      end
    end
    if (budget >= 3000) chk("frame_timeout", 1, 0);
    chk("frame_last_done", 32'(bus.out_done), 1);
    chk("frame_last_bin",  32'(bus.o_counter_data), 255);
    chk("nodata_cycles",   32'(nodata), 32'(nnull));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_done === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_strobe", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("bin_index", 32'(bus.o_counter_data), e.k);
        chk("bin_i",     32'(bus.out_data_i), 32'(e.i));
        chk("bin_q",     32'(bus.out_data_q), 32'(e.q));
      end
    end
  end

  initial begin
    build_model();
    rst = 1'b1;
    bus.in_data_en = 1'b1;
    bus.i_wayt_recive_data = 1'b1;
    bus.in_data_i = 16'h0001;
    bus.in_data_q = 16'hFFFF;
    #12;
    chk("rst_done",  32'(bus.out_done), 0);
    chk("rst_i",     32'(bus.out_data_i), 0);
    chk("rst_q",     32'(bus.out_data_q), 0);
    chk("rst_cnt",   32'(bus.o_counter_data), 0);
    chk("rst_ready", 32'(bus.o_flag_ready_recive), 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE must wait for a valid symbol before releasing bin 0
    repeat (3) begin
      cyc(1'b0, 1'b1);
      chk("idle_no_strobe", 32'(bus.out_done), 0);
    end

    run_frame(19, 50, -1);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, 30);
    run_frame(-1, -1, -1);

    // After wrap the generator idles and holds the last bin
    repeat (3) begin
      cyc(1'b0, 1'b1);
      chk("post_no_strobe", 32'(bus.out_done), 0);
      chk("post_hold_cnt",  32'(bus.o_counter_data), 255);
    end
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
